// File: rtl/button_sequence_checker.sv
`default_nettype none
//==============================================================================
// Module : button_sequence_checker
// Brief  : Snapshots a generated button sequence on arm and checks player
//          presses against it, reporting pass or fail with a cause.
//          Define STRIKES_EN to tolerate MAX_STRIKES-1 wrong presses.
// Rev    : 1.0
//==============================================================================
module button_sequence_checker #(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_STRIKES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] buttons [0:MAX_LEN-1],
    input  logic [5:0] count,
    input  logic       seq_valid,
    input  logic       arm,
    input  logic       press_valid,
    input  logic [3:0] press_code,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_cause,
    output logic [4:0] progress
`ifdef STRIKES_EN
    ,
    output logic [1:0] strikes
`endif
);

    localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] C_TIMER_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [5:0]    C_MAX_LEN6    = 6'(MAX_LEN);
    localparam logic [4:0]    C_MAX_LEN5    = 5'(MAX_LEN);
    localparam logic [1:0]    C_CAUSE_NONE  = 2'd0;
    localparam logic [1:0]    C_CAUSE_WRONG = 2'd1;
    localparam logic [1:0]    C_CAUSE_TIME  = 2'd2;
`ifdef STRIKES_EN
    localparam logic [2:0]    C_MAX_STRIKES = 3'(MAX_STRIKES);
`else
    localparam int            C_UNUSED_MAX_STRIKES = MAX_STRIKES;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_arm_q;
    logic [3:0]    r_snap [0:MAX_LEN-1];
    logic [4:0]    r_len;
    logic [4:0]    w_len_nx;
    logic [4:0]    r_progress;
    logic [4:0]    w_progress_nx;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_nx;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nx;
    logic          w_load_snap;
    logic          w_arm_ok;
    logic          w_match;
    logic          w_timeout;
    logic [4:0]    w_count_len;
`ifdef STRIKES_EN
    logic [1:0]    r_strikes;
    logic [1:0]    w_strikes_nx;
    logic          w_strike_limit;
`endif

    assign w_arm_ok    = arm && !r_arm_q && seq_valid;
    // Oversized counts saturate at the storage depth rather than wrapping.
    assign w_count_len = (count > C_MAX_LEN6) ? C_MAX_LEN5 : count[4:0];
    assign w_match     = (press_code == r_snap[r_progress[IW-1:0]]);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_timer == '0);
`ifdef STRIKES_EN
    assign w_strike_limit = (({1'b0, r_strikes} + 3'd1) >= C_MAX_STRIKES);
`endif

    always_comb begin
        w_state_nx    = r_state;
        w_len_nx      = r_len;
        w_progress_nx = r_progress;
        w_cause_nx    = r_cause;
        w_timer_nx    = r_timer;
        w_load_snap   = 1'b0;
`ifdef STRIKES_EN
        w_strikes_nx  = r_strikes;
`endif
        case (r_state)
            S_CHECK: begin
                // A press in the expiry cycle wins over the timeout.
                if (press_valid) begin
                    w_timer_nx = C_TIMER_LOAD;
                    if (w_match) begin
                        w_progress_nx = r_progress + 5'd1;
                        if ((r_progress + 5'd1) == r_len) begin
                            w_state_nx = S_PASS;
                        end
                    end else begin
`ifdef STRIKES_EN
                        w_strikes_nx = r_strikes + 2'd1;
                        if (w_strike_limit) begin
                            w_state_nx = S_FAIL;
                            w_cause_nx = C_CAUSE_WRONG;
                        end
`else
                        w_state_nx = S_FAIL;
                        w_cause_nx = C_CAUSE_WRONG;
`endif
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_FAIL;
                    w_cause_nx = C_CAUSE_TIME;
                end else if (r_timer != '0) begin
                    w_timer_nx = r_timer - TW'(1);
                end
            end
            default: begin
                if (w_arm_ok) begin
                    w_load_snap   = 1'b1;
                    w_len_nx      = w_count_len;
                    w_progress_nx = 5'd0;
                    w_cause_nx    = C_CAUSE_NONE;
                    w_timer_nx    = C_TIMER_LOAD;
`ifdef STRIKES_EN
                    w_strikes_nx  = 2'd0;
`endif
                    w_state_nx    = (w_count_len == 5'd0) ? S_PASS : S_CHECK;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_arm_q    <= 1'b0;
            r_len      <= 5'd0;
            r_progress <= 5'd0;
            r_cause    <= C_CAUSE_NONE;
            r_timer    <= '0;
`ifdef STRIKES_EN
            r_strikes  <= 2'd0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_arm_q    <= arm;
            r_len      <= w_len_nx;
            r_progress <= w_progress_nx;
            r_cause    <= w_cause_nx;
            r_timer    <= w_timer_nx;
`ifdef STRIKES_EN
            r_strikes  <= w_strikes_nx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_snap) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_snap[i] <= buttons[i];
            end
        end
    end

    assign busy       = (r_state == S_CHECK);
    assign pass       = (r_state == S_PASS);
    assign fail       = (r_state == S_FAIL);
    assign fail_cause = r_cause;
    assign progress   = r_progress;
`ifdef STRIKES_EN
    assign strikes    = r_strikes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_sequence_checker.sv
`default_nettype none
//==============================================================================
// Module : tb_button_sequence_checker
// Brief  : Randomised and directed bench for button_sequence_checker against
//          a queue-based reference model.
// Rev    : 1.0
//==============================================================================
module tb_button_sequence_checker;

    localparam int MAX_LEN        = 16;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int MAX_STRIKES    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] buttons [0:MAX_LEN-1];
    logic [5:0] count;
    logic       seq_valid;
    logic       arm;
    logic       press_valid;
    logic [3:0] press_code;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] fail_cause;
    logic [4:0] progress;
`ifdef STRIKES_EN
    logic [1:0] strikes;
`endif

    button_sequence_checker #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_STRIKES    (MAX_STRIKES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buttons     (buttons),
        .count       (count),
        .seq_valid   (seq_valid),
        .arm         (arm),
        .press_valid (press_valid),
        .press_code  (press_code),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .fail_cause  (fail_cause),
        .progress    (progress)
`ifdef STRIKES_EN
        ,
        .strikes     (strikes)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining behaviour expressed as a list of expected
    // codes, a pointer into it and a count of press-free cycles.
    bit         m_active, m_pass, m_fail, m_arm_prev;
    int         m_cause, m_prog, m_len, m_idle, m_strikes;
    logic [3:0] m_seq [$];
    logic [3:0] saved [0:MAX_LEN-1];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (!rst) begin
            m_active = 0; m_pass = 0; m_fail = 0; m_arm_prev = 0;
            m_cause = 0; m_prog = 0; m_len = 0; m_idle = 0; m_strikes = 0;
            return;
        end
        rise = arm && !m_arm_prev;
        m_arm_prev = arm;
        if (m_active) begin
            if (press_valid) begin
                m_idle = 0;
                if (press_code == m_seq[m_prog]) begin
                    m_prog++;
                    if (m_prog == m_len) begin
                        m_active = 0;
                        m_pass = 1;
                    end
                end else begin
`ifdef STRIKES_EN
                    m_strikes++;
                    if (m_strikes >= MAX_STRIKES) begin
                        m_active = 0; m_fail = 1; m_cause = 1;
                    end
`else
                    m_active = 0; m_fail = 1; m_cause = 1;
`endif
                end
            end else begin
                m_idle++;
                if (m_idle > TIMEOUT_CYCLES) begin
                    m_active = 0; m_fail = 1; m_cause = 2;
                end
            end
        end else if (rise && seq_valid) begin
            m_len = (int'(count) > MAX_LEN) ? MAX_LEN : int'(count);
            m_seq = {};
            for (int i = 0; i < m_len; i++) m_seq.push_back(buttons[i]);
            m_prog = 0; m_pass = 0; m_fail = 0; m_cause = 0; m_idle = 0; m_strikes = 0;
            if (m_len == 0) m_pass = 1;
            else            m_active = 1;
        end
    endtask

    task automatic run_cycle(input bit pv, input logic [3:0] pc);
        press_valid = pv;
        press_code  = pc;
        model_step();
        @(posedge clk);
        #1;
        check_value("busy", 32'(busy), 32'(m_active));
        check_value("pass", 32'(pass), 32'(m_pass));
        check_value("fail", 32'(fail), 32'(m_fail));
        check_value("fail_cause", 32'(fail_cause), m_cause);
        check_value("progress", 32'(progress), m_prog);
`ifdef STRIKES_EN
        check_value("strikes", 32'(strikes), m_strikes);
`endif
        press_valid = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b0;
        run_cycle(1'b0, 4'd0);
        arm = 1'b1;
        run_cycle(1'b0, 4'd0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < MAX_LEN; i++) buttons[i] = 4'd0;
        buttons[0] = 4'd3; buttons[1] = 4'd7; buttons[2] = 4'd1; buttons[3] = 4'd9;
        count = 6'd4;
        seq_valid = 1'b1;
    endtask

    initial begin
        bit slow;
        int r;
        rst = 1'b0; arm = 1'b0; seq_valid = 1'b0; count = 6'd0;
        press_valid = 1'b0; press_code = 4'd0;
        for (int i = 0; i < MAX_LEN; i++) buttons[i] = 4'd0;

        run_cycle(1'b0, 4'd0);
        run_cycle(1'b0, 4'd0);
        check_value("reset_busy", 32'(busy), 32'd0);
        check_value("reset_progress", 32'(progress), 32'd0);
        rst = 1'b1;

        // Full correct sequence.
        load_basic();
        arm_pulse();
        check_value("armed_busy", 32'(busy), 32'd1);
        run_cycle(1'b1, 4'd3);
        run_cycle(1'b1, 4'd7);
        run_cycle(1'b1, 4'd1);
        run_cycle(1'b1, 4'd9);
        check_value("seq_pass", 32'(pass), 32'd1);
        check_value("seq_progress", 32'(progress), 32'd4);

        // Wrong second press, then an ignored press.
        arm_pulse();
        run_cycle(1'b1, 4'd3);
        run_cycle(1'b1, 4'd5);
        run_cycle(1'b1, 4'd7);
`ifndef STRIKES_EN
        check_value("wrong_cause", 32'(fail_cause), 32'd1);
        check_value("wrong_progress", 32'(progress), 32'd1);
`endif

        // Timeout with no presses.
        arm_pulse();
        for (int c = 0; c < TIMEOUT_CYCLES; c++) run_cycle(1'b0, 4'd0);
        check_value("pre_timeout_busy", 32'(busy), 32'd1);
        run_cycle(1'b0, 4'd0);
        check_value("timeout_fail", 32'(fail), 32'd1);
        check_value("timeout_cause", 32'(fail_cause), 32'd2);

        // Press on the expiry cycle wins; then reset mid-check.
        arm_pulse();
        for (int c = 0; c < TIMEOUT_CYCLES; c++) run_cycle(1'b0, 4'd0);
        run_cycle(1'b1, 4'd3);
        check_value("expiry_press_fail", 32'(fail), 32'd0);
        check_value("expiry_press_prog", 32'(progress), 32'd1);
        run_cycle(1'b1, 4'd7);
        rst = 1'b0;
        run_cycle(1'b0, 4'd0);
        check_value("midrst_progress", 32'(progress), 32'd0);
        check_value("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Empty sequence passes immediately.
        count = 6'd0;
        arm_pulse();
        check_value("empty_pass", 32'(pass), 32'd1);

        // Oversized count clamps; buttons change after arming.
        for (int i = 0; i < MAX_LEN; i++) begin
            saved[i] = 4'($urandom_range(0, 15));
            buttons[i] = saved[i];
        end
        count = 6'd20;
        arm_pulse();
        for (int i = 0; i < MAX_LEN; i++) buttons[i] = ~saved[i];
        count = 6'd2;
        for (int i = 0; i < MAX_LEN; i++) run_cycle(1'b1, saved[i]);
        check_value("clamp_pass", 32'(pass), 32'd1);
        check_value("clamp_progress", 32'(progress), 32'd16);

`ifdef STRIKES_EN
        load_basic();
        arm_pulse();
        run_cycle(1'b1, 4'd5);
        run_cycle(1'b1, 4'd5);
        check_value("strikes_two", 32'(strikes), 32'd2);
        check_value("strikes_busy", 32'(busy), 32'd1);
        run_cycle(1'b1, 4'd5);
        check_value("strikes_fail", 32'(fail), 32'd1);
`endif

        // Randomised trials.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < MAX_LEN; i++) buttons[i] = 4'($urandom_range(0, 15));
            count = 6'($urandom_range(0, 20));
            seq_valid = ($urandom_range(0, 7) != 0);
            slow = ($urandom_range(0, 3) == 0);
            arm_pulse();
            for (int c = 0; c < 40; c++) begin
                r = $urandom_range(0, 99);
                if ($urandom_range(0, 24) == 0) arm = ~arm;
                if ($urandom_range(0, 29) == 0) buttons[$urandom_range(0, MAX_LEN-1)] = 4'($urandom);
                rst = ($urandom_range(0, 149) != 0);
                if (slow ? (r < 8) : (r < 60)) begin
                    if (m_active && (r % 8 != 0)) run_cycle(1'b1, m_seq[m_prog]);
                    else                          run_cycle(1'b1, 4'($urandom_range(0, 15)));
                end else begin
                    run_cycle(1'b0, 4'($urandom));
                end
            end
            rst = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
